// File: rtl/instr_hold_sequencer.sv
// Multi-cycle instruction hold sequencer: captures an address/opcode pair,
// holds it for a per-opcode latency read from a run-time writable table,
// then accepts the next instruction. Supports stall, flush and valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | hold counter is 0; a new instruction may be captured
// HOLD  | hold counter non-zero; outputs frozen, counting down to 0
module instr_hold_sequencer #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 3,
  parameter logic [(2**OP_W)*CNT_W-1:0] LAT_INIT =
    {3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd3, 3'd0}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address,
  input  logic [OP_W-1:0]   opcode,
  input  logic              stall,
  input  logic              flush,
  input  logic              cfg_we,
  input  logic [OP_W-1:0]   cfg_idx,
  input  logic [CNT_W-1:0]  cfg_lat,
  output logic [ADDR_W-1:0] out_address,
  output logic [OP_W-1:0]   out_opcode,
  output logic              busy,
  output logic [CNT_W-1:0]  remaining,
  output logic              done
);

  localparam int N_OP = 2**OP_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_tbl [N_OP];
  logic [CNT_W-1:0] cap_lat;
  logic [0:0]       state;
  logic             capture;
  logic             cnt_tc;

  // State is implied by the down-counter: non-zero means a hold is running.
  assign state     = (cnt != '0) ? ST_HOLD : ST_IDLE;
  assign in_ready  = (state == ST_IDLE) && !flush;
  assign capture   = in_ready && in_valid;
  assign cnt_tc    = (cnt == CNT_W'(1));
  // Table read happens before any same-edge write lands, so capture sees the old value.
  assign cap_lat   = lat_tbl[opcode];
  assign busy      = (state == ST_HOLD);
  assign remaining = cnt;

  // Latency table: reloaded on reset, single-entry write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OP; i++) begin
        lat_tbl[i] <= LAT_INIT[i*CNT_W +: CNT_W];
      end
    end else if (cfg_we) begin
      lat_tbl[cfg_idx] <= cfg_lat;
    end
  end

  // Hold down-counter: flush clears, capture loads, otherwise count unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (capture) begin
      cnt <= cap_lat;
    end else if ((state == ST_HOLD) && !stall) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Held instruction registers: only change on capture, survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_address <= '0;
      out_opcode  <= '0;
    end else if (capture) begin
      out_address <= address;
      out_opcode  <= opcode;
    end
  end

  // Completion pulse: terminal count reached, or zero-latency capture; never on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (flush) begin
      done <= 1'b0;
    end else if (capture) begin
      done <= (cap_lat == '0);
    end else begin
      done <= (state == ST_HOLD) && !stall && cnt_tc;
    end
  end

endmodule

// File: tb/tb_instr_hold_sequencer.sv
// Bench for instr_hold_sequencer: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_instr_hold_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] address = '0;
  logic [2:0] opcode = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [2:0] cfg_lat = '0;
  logic [4:0] out_address;
  logic [2:0] out_opcode;
  logic       busy;
  logic [2:0] remaining;
  logic       done;

  int checks = 0;
  int passes = 0;

  instr_hold_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .opcode(opcode), .stall(stall), .flush(flush),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lat(cfg_lat),
    .out_address(out_address), .out_opcode(out_opcode), .busy(busy),
    .remaining(remaining), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural reference: integer hold time, table as plain array.
  int       m_rem;
  int       m_tbl [8];
  bit [4:0] m_addr;
  bit [2:0] m_op;
  bit       m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_addr = 0; m_op = 0; m_done = 0;
      m_tbl = '{0, 3, 5, 5, 5, 5, 4, 3};
    end else begin
      int old_lat;
      bit accept;
      accept  = (m_rem == 0) && !flush && in_valid;
      old_lat = m_tbl[opcode];
      if (cfg_we) m_tbl[cfg_idx] = int'(cfg_lat);
      if (flush) begin
        m_rem = 0; m_done = 0;
      end else if (accept) begin
        m_addr = address; m_op = opcode; m_rem = old_lat; m_done = (old_lat == 0);
      end else if (m_rem > 0 && !stall) begin
        m_rem = m_rem - 1; m_done = (m_rem == 0);
      end else begin
        m_done = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; stall = 0; flush = 0; cfg_we = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 20) begin cyc(); n++; end
    checks++; if (busy !== 1'b0) $display("FAIL wait_idle timeout busy=%b required 0", busy); else passes++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; #12; rst_n = 1; cyc();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b required 1", in_ready); else passes++;
    checks++; if (out_address !== 5'h00) $display("FAIL reset_addr got %h required 00", out_address); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b required 0", done); else passes++;
  endtask

  task automatic test_basic_hold();
    in_valid = 1; opcode = 3'd1; address = 5'h15; cyc(); in_valid = 0;
    checks++; if (out_address !== 5'h15) $display("FAIL basic_addr got %h required 15", out_address); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %b required 1", busy); else passes++;
    for (int r = 3; r >= 1; r--) begin
      checks++; if (remaining !== 3'(r)) $display("FAIL basic_rem got %0d required %0d", remaining, r); else passes++;
      cyc();
    end
    checks++; if (done !== 1'b1 || in_ready !== 1'b1) $display("FAIL basic_done got done=%b rdy=%b required 1/1", done, in_ready); else passes++;
    cyc();
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b required 0", done); else passes++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1; opcode = 3'd0;
    for (int a = 1; a <= 3; a++) begin
      address = 5'(a); cyc();
      checks++; if (out_address !== 5'(a) || busy !== 1'b0 || done !== 1'b1)
        $display("FAIL b2b_%0d got addr=%h busy=%b done=%b required %h/0/1", a, out_address, busy, done, 5'(a)); else passes++;
    end
    in_valid = 0; cyc();
    checks++; if (done !== 1'b0) $display("FAIL b2b_done_end got %b required 0", done); else passes++;
  endtask

  task automatic test_stall();
    int edges = 0;
    in_valid = 1; opcode = 3'd2; address = 5'h07; cyc(); in_valid = 0; edges++;
    while (remaining !== 3'd3 && edges < 10) begin cyc(); edges++; end
    stall = 1; cyc(); edges++;
    checks++; if (remaining !== 3'd3) $display("FAIL stall_rem1 got %0d required 3", remaining); else passes++;
    cyc(); edges++;
    checks++; if (remaining !== 3'd3) $display("FAIL stall_rem2 got %0d required 3", remaining); else passes++;
    stall = 0;
    while (done !== 1'b1 && edges < 20) begin cyc(); edges++; end
    checks++; if (edges != 8) $display("FAIL stall_total got %0d cycles required 8", edges); else passes++;
  endtask

  task automatic test_flush();
    in_valid = 1; opcode = 3'd6; address = 5'h1C; cyc(); in_valid = 0;
    checks++; if (remaining !== 3'd4) $display("FAIL flush_load got %0d required 4", remaining); else passes++;
    cyc(); cyc();
    flush = 1; in_valid = 1; opcode = 3'd1; address = 5'h0A; #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %b required 0", in_ready); else passes++;
    cyc(); flush = 0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || out_address !== 5'h1C)
      $display("FAIL flush_abort got busy=%b done=%b addr=%h required 0/0/1c", busy, done, out_address); else passes++;
    cyc(); in_valid = 0;
    checks++; if (out_address !== 5'h0A || remaining !== 3'd3)
      $display("FAIL flush_recapture got addr=%h rem=%0d required 0a/3", out_address, remaining); else passes++;
    wait_idle();
  endtask

  task automatic test_cfg();
    cfg_we = 1; cfg_idx = 3'd1; cfg_lat = 3'd7; in_valid = 1; opcode = 3'd1; cyc();
    cfg_we = 0; in_valid = 0;
    checks++; if (remaining !== 3'd3) $display("FAIL cfg_old got %0d required 3", remaining); else passes++;
    wait_idle();
    in_valid = 1; opcode = 3'd1; cyc(); in_valid = 0;
    checks++; if (remaining !== 3'd7) $display("FAIL cfg_new got %0d required 7", remaining); else passes++;
    wait_idle();
  endtask

  task automatic test_async_reset();
    in_valid = 1; opcode = 3'd2; address = 5'h11; cyc(); in_valid = 0; cyc();
    checks++; if (remaining !== 3'd4) $display("FAIL arst_pre got %0d required 4", remaining); else passes++;
    #1 rst_n = 0; #1;
    checks++; if (busy !== 1'b0 || out_address !== 5'h00 || remaining !== 3'd0)
      $display("FAIL arst_now got busy=%b addr=%h rem=%0d required 0/00/0", busy, out_address, remaining); else passes++;
    @(negedge clk); rst_n = 1; cyc();
    in_valid = 1; opcode = 3'd1; cyc(); in_valid = 0;
    checks++; if (remaining !== 3'd3) $display("FAIL arst_table got %0d required 3", remaining); else passes++;
    wait_idle();
  endtask

  task automatic test_random();
    idle_inputs(); cyc();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      address  = 5'($urandom);
      opcode   = 3'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_idx  = 3'($urandom);
      cfg_lat  = 3'($urandom);
      #1;
      checks++; if (in_ready !== ((m_rem == 0) && !flush)) $display("FAIL rnd_ready[%0d] got %b model rem=%0d flush=%b", i, in_ready, m_rem, flush); else passes++;
      cyc();
      checks++;
      if (remaining !== 3'(m_rem) || busy !== (m_rem != 0) || done !== m_done ||
          out_address !== m_addr || out_opcode !== m_op)
        $display("FAIL rnd_state[%0d] got rem=%0d busy=%b done=%b addr=%h op=%0d required %0d/%b/%b/%h/%0d",
                 i, remaining, busy, done, out_address, out_opcode, m_rem, m_rem != 0, m_done, m_addr, m_op);
      else passes++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_hold();
    test_back_to_back();
    test_stall();
    test_flush();
    test_cfg();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
